// File: rtl/freq_meter_pkg.sv
// -----------------------------------------------------------------------------
// freq_meter_pkg
// Shared definitions for the multi-channel equal-precision frequency meter:
//   - ch_state_t   : per-channel measurement FSM states
//   - FREQ_SAT_ALL : all-ones pattern used when a quotient overflows FREQ_W
//   - div_width()  : dividend width derived from the counter width
// -----------------------------------------------------------------------------
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_DONE = 2'd3
    } ch_state_t;

    // Wide enough for any sane FREQ_W; sliced down at the point of use.
    localparam logic [127:0] FREQ_SAT_ALL = '1;

    // nx * CLK_FREQ_HZ needs twice the counter width.
    function automatic int div_width(input int cnt_w);
        return 2 * cnt_w;
    endfunction

endpackage

// File: rtl/freq_div_seq.sv
// -----------------------------------------------------------------------------
// freq_div_seq
// Restoring unsigned divider, one quotient bit per cycle, with saturation.
// A start pulse loads the operands, DIV_W iterations follow, then done pulses
// for one cycle with the quotient valid alongside it.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   start              : load dividend/divisor (ignored while running)
//   dividend, divisor  : DIV_W-bit unsigned operands (divisor must be != 0)
//   done               : one-cycle pulse, quotient valid
//   quotient           : Q_W-bit result, all-ones if it does not fit in Q_W
// -----------------------------------------------------------------------------
module freq_div_seq
    import freq_meter_pkg::*;
#(
    parameter int DIV_W = 64,
    parameter int Q_W   = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int CW = $clog2(DIV_W + 1);

    logic [DIV_W-1:0] rem_q;
    logic [DIV_W-1:0] quo_q;
    logic [DIV_W-1:0] div_q;
    logic [CW-1:0]    cnt_q;
    logic             running;
    logic [DIV_W:0]   shifted;
    logic [DIV_W:0]   diff;

    // quo_q holds the unconsumed dividend bits at the top and the quotient
    // bits shifting in from the bottom.
    assign shifted = {rem_q, quo_q[DIV_W-1]};
    assign diff    = shifted - {1'b0, div_q};

    // One restoring step per cycle; the sign bit of diff decides the bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!running) begin
                if (start) begin
                    rem_q   <= '0;
                    quo_q   <= dividend;
                    div_q   <= divisor;
                    cnt_q   <= CW'(DIV_W);
                    running <= 1'b1;
                end
            end else begin
                if (!diff[DIV_W]) begin
                    rem_q <= diff[DIV_W-1:0];
                    quo_q <= {quo_q[DIV_W-2:0], 1'b1};
                end else begin
                    rem_q <= shifted[DIV_W-1:0];
                    quo_q <= {quo_q[DIV_W-2:0], 1'b0};
                end
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    generate
        if (DIV_W > Q_W) begin : g_sat
            assign quotient = (|quo_q[DIV_W-1:Q_W]) ? FREQ_SAT_ALL[Q_W-1:0]
                                                     : quo_q[Q_W-1:0];
        end else begin : g_nosat
            assign quotient = Q_W'(quo_q);
        end
    endgenerate

endmodule

// File: rtl/freq_meter_mc.sv
// -----------------------------------------------------------------------------
// freq_meter_mc
// Multi-channel equal-precision frequency meter. Each channel's gate opens and
// closes on its own test-signal rising edges; a shared divider turns the
// counts into Hz once per measurement window.
// Ports:
//   sys_clk, sys_rst_n : only clock, asynchronous active-low reset
//   clk_test[CH_NUM]   : asynchronous test inputs
//   freq               : channel i in [i*FREQ_W +: FREQ_W], unsigned Hz
//   freq_valid         : one-cycle pulse per channel when freq updates
//   no_sig             : 1 = last window found no complete gate
//   busy               : divider sequence in progress
// Optional (macro FREQ_METER_RAW_EN): raw_nx, raw_nr snapshot count outputs.
// -----------------------------------------------------------------------------
module freq_meter_mc
    import freq_meter_pkg::*;
#(
    parameter int CH_NUM      = 4,
    parameter int CLK_FREQ_HZ = 48_000_000,
    parameter int GATE_CYCLES = 48_000_000,
    parameter int WIN_CYCLES  = 60_000_000,
    parameter int CNT_W       = 32,
    parameter int FREQ_W      = 32
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [CH_NUM-1:0]        clk_test,
    output logic [CH_NUM*FREQ_W-1:0] freq,
    output logic [CH_NUM-1:0]        freq_valid,
    output logic [CH_NUM-1:0]        no_sig,
    output logic                     busy
`ifdef FREQ_METER_RAW_EN
    ,
    output logic [CH_NUM*CNT_W-1:0]  raw_nx,
    output logic [CH_NUM*CNT_W-1:0]  raw_nr
`endif
);

    localparam int DIV_W = div_width(CNT_W);
    localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    logic [CNT_W-1:0] cnt_win;
    logic             win_end;
    logic             gate_s;

    logic [CNT_W-1:0] snap_nx [CH_NUM];
    logic [CNT_W-1:0] snap_nr [CH_NUM];
    logic [CH_NUM-1:0] snap_ok;

    assign win_end = (cnt_win == CNT_W'(WIN_CYCLES - 1));
    assign gate_s  = (cnt_win < CNT_W'(GATE_CYCLES));

    // Free-running window counter shared by every channel.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cnt_win <= '0;
        else if (win_end) cnt_win <= '0;
        else cnt_win <= cnt_win + 1'b1;
    end

    generate
        for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
            logic [2:0]       sync_q;
            logic             edge_det;
            ch_state_t        state;
            logic [CNT_W-1:0] nx;
            logic [CNT_W-1:0] nr;
            logic [CNT_W-1:0] nx_snap;
            logic [CNT_W-1:0] nr_snap;
            logic             ok_snap;

            // Two synchronizer stages plus one history flop; the latency is
            // identical for every edge so it cancels out of nr.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) sync_q <= '0;
                else sync_q <= {sync_q[1:0], clk_test[i]};
            end
            assign edge_det = sync_q[1] & ~sync_q[2];

            // Gate FSM. An edge arriving in the same cycle gate_s drops is
            // already seen with gate_s low, so it becomes the stop edge.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    state   <= ST_IDLE;
                    nx      <= '0;
                    nr      <= '0;
                    nx_snap <= '0;
                    nr_snap <= '0;
                    ok_snap <= 1'b0;
                end else if (win_end) begin
                    nx_snap <= nx;
                    nr_snap <= nr;
                    ok_snap <= (state == ST_DONE);
                    state   <= ST_IDLE;
                end else begin
                    case (state)
                        ST_IDLE: if (cnt_win == '0) state <= ST_ARM;
                        ST_ARM: begin
                            if (!gate_s) begin
                                state <= ST_IDLE;
                            end else if (edge_det) begin
                                nx    <= '0;
                                nr    <= '0;
                                state <= ST_MEAS;
                            end
                        end
                        ST_MEAS: begin
                            nr <= nr + 1'b1;
                            if (edge_det) begin
                                nx <= nx + 1'b1;
                                if (!gate_s) state <= ST_DONE;
                            end
                        end
                        default: state <= state;
                    endcase
                end
            end

            assign snap_nx[i] = nx_snap;
            assign snap_nr[i] = nr_snap;
            assign snap_ok[i] = ok_snap;
`ifdef FREQ_METER_RAW_EN
            assign raw_nx[i*CNT_W +: CNT_W] = nx_snap;
            assign raw_nr[i*CNT_W +: CNT_W] = nr_snap;
`endif
        end
    endgenerate

    logic             seq_go;
    logic [IDX_W-1:0] seq_idx;
    logic [CNT_W-1:0] sel_nx;
    logic [CNT_W-1:0] sel_nr;
    logic             bypass;
    logic             div_start;
    logic             div_done;
    logic [DIV_W-1:0] div_dividend;
    logic [DIV_W-1:0] div_divisor;
    logic [FREQ_W-1:0] div_quot;

    assign sel_nx       = snap_nx[seq_idx];
    assign sel_nr       = snap_nr[seq_idx];
    assign bypass       = !snap_ok[seq_idx] || (sel_nr == '0);
    assign div_start    = seq_go && !bypass;
    assign div_dividend = DIV_W'(sel_nx) * DIV_W'(CLK_FREQ_HZ);
    assign div_divisor  = DIV_W'(sel_nr);

    freq_div_seq #(
        .DIV_W (DIV_W),
        .Q_W   (FREQ_W)
    ) u_div (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .done      (div_done),
        .quotient  (div_quot)
    );

    // Channel sequencer. seq_go marks the start cycle of channel seq_idx; the
    // next channel starts in the same cycle the previous result is visible,
    // so channels without a signal only cost one cycle.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            freq       <= '0;
            freq_valid <= '0;
            no_sig     <= '0;
            busy       <= 1'b0;
            seq_go     <= 1'b0;
            seq_idx    <= '0;
        end else begin
            freq_valid <= '0;
            if (win_end) begin
                busy    <= 1'b1;
                seq_go  <= 1'b1;
                seq_idx <= '0;
            end else begin
                if (freq_valid[CH_NUM-1]) busy <= 1'b0;
                if (seq_go && bypass) begin
                    freq[seq_idx*FREQ_W +: FREQ_W] <= '0;
                    no_sig[seq_idx]     <= 1'b1;
                    freq_valid[seq_idx] <= 1'b1;
                    if (seq_idx == IDX_W'(CH_NUM - 1)) seq_go <= 1'b0;
                    else seq_idx <= seq_idx + 1'b1;
                end else if (seq_go) begin
                    seq_go <= 1'b0;
                end else if (div_done) begin
                    freq[seq_idx*FREQ_W +: FREQ_W] <= div_quot;
                    no_sig[seq_idx]     <= 1'b0;
                    freq_valid[seq_idx] <= 1'b1;
                    if (seq_idx != IDX_W'(CH_NUM - 1)) begin
                        seq_idx <= seq_idx + 1'b1;
                        seq_go  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_meter_mc.sv
// -----------------------------------------------------------------------------
// tb_freq_meter_mc
// Table-driven bench for freq_meter_mc: each vector sets the test-signal
// periods (0 = held low), runs one full window from reset and compares the
// captured results, pulse order/spacing and busy against hand-computed values.
// A hand-written sequence covers reset in the middle of the divider sequence.
// Optional (macro FREQ_METER_RAW_EN): raw_nx/raw_nr snapshot checks.
// -----------------------------------------------------------------------------
module tb_freq_meter_mc;

    localparam int CH_NUM      = 4;
    localparam int CLK_FREQ_HZ = 100_000;
    localparam int GATE_CYCLES = 10_000;
    localparam int WIN_CYCLES  = 12_000;
    localparam int CNT_W       = 24;
    localparam int FREQ_W      = 32;
    localparam int DIV_LAT     = 2 * CNT_W + 2;

    typedef struct {
        int period   [CH_NUM];
        int exp_freq [CH_NUM];
        int exp_ns   [CH_NUM];
    } vec_t;

    logic                     sys_clk   = 1'b0;
    logic                     sys_rst_n = 1'b0;
    logic [CH_NUM-1:0]        clk_test  = '0;
    logic [CH_NUM*FREQ_W-1:0] freq;
    logic [CH_NUM-1:0]        freq_valid;
    logic [CH_NUM-1:0]        no_sig;
    logic                     busy;
`ifdef FREQ_METER_RAW_EN
    logic [CH_NUM*CNT_W-1:0]  raw_nx;
    logic [CH_NUM*CNT_W-1:0]  raw_nr;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int period [CH_NUM] = '{0, 0, 0, 0};
    int tb_cyc;
    int pulse_cnt [CH_NUM];
    int first_t   [CH_NUM];
    int cap_freq  [CH_NUM];
    int cap_ns    [CH_NUM];
    int cap_busy  [CH_NUM];
    int overlap_cnt;

    freq_meter_mc #(
        .CH_NUM      (CH_NUM),
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .GATE_CYCLES (GATE_CYCLES),
        .WIN_CYCLES  (WIN_CYCLES),
        .CNT_W       (CNT_W),
        .FREQ_W      (FREQ_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .clk_test   (clk_test),
        .freq       (freq),
        .freq_valid (freq_valid),
        .no_sig     (no_sig),
        .busy       (busy)
`ifdef FREQ_METER_RAW_EN
        ,
        .raw_nx     (raw_nx),
        .raw_nr     (raw_nr)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Cycles since reset release; equals the DUT window counter in window 0.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) tb_cyc <= 0;
        else tb_cyc <= tb_cyc + 1;
    end

    // Square-wave generators locked to tb_cyc so edge phases are known.
    always @(negedge sys_clk) begin
        for (int i = 0; i < CH_NUM; i++)
            clk_test[i] = (period[i] != 0) && ((tb_cyc % period[i]) >= (period[i] / 2));
    end

    // Pulse monitor: records first pulse time and the values seen with it.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            overlap_cnt = 0;
            for (int i = 0; i < CH_NUM; i++) begin
                pulse_cnt[i] = 0;
                first_t[i]   = -1;
                cap_freq[i]  = -1;
                cap_ns[i]    = -1;
                cap_busy[i]  = -1;
            end
        end else begin
            if ($countones(freq_valid) > 1) overlap_cnt++;
            for (int i = 0; i < CH_NUM; i++) begin
                if (freq_valid[i]) begin
                    if (pulse_cnt[i] == 0) first_t[i] = tb_cyc;
                    pulse_cnt[i]++;
                    cap_freq[i] = int'(freq[i*FREQ_W +: FREQ_W]);
                    cap_ns[i]   = int'(no_sig[i]);
                    cap_busy[i] = int'(busy);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        sys_rst_n = 1'b0;
        for (int i = 0; i < CH_NUM; i++) period[i] = v.period[i];
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic runToCycle(input int cyc);
        while (tb_cyc < cyc) @(negedge sys_clk);
    endtask

    task automatic checkVector(input int k, input vec_t v);
        int dur;
        for (int i = 0; i < CH_NUM; i++) begin
            checkOutput($sformatf("v%0d ch%0d freq", k, i), cap_freq[i], v.exp_freq[i]);
            checkOutput($sformatf("v%0d ch%0d no_sig", k, i), cap_ns[i], v.exp_ns[i]);
            checkOutput($sformatf("v%0d ch%0d pulse count", k, i), pulse_cnt[i], 1);
            checkOutput($sformatf("v%0d ch%0d busy at pulse", k, i), cap_busy[i], 1);
            dur = (v.exp_ns[i] != 0) ? 1 : DIV_LAT;
            if (i == 0)
                checkOutput($sformatf("v%0d ch0 pulse time", k), first_t[0], WIN_CYCLES + dur);
            else
                checkOutput($sformatf("v%0d ch%0d spacing", k, i), first_t[i] - first_t[i-1], dur);
        end
        checkOutput($sformatf("v%0d busy after sequence", k), busy, 0);
        checkOutput($sformatf("v%0d overlap", k), overlap_cnt, 0);
    endtask

    vec_t vecs [3];

    initial begin
        int total;

        vecs[0].period = '{10, 7, 3000, 0};
        vecs[0].exp_freq = '{10_000, 14_285, 33, 0};
        vecs[0].exp_ns = '{0, 0, 0, 1};
        vecs[1].period = '{10, 7, 3000, 20};
        vecs[1].exp_freq = '{10_000, 14_285, 33, 5_000};
        vecs[1].exp_ns = '{0, 0, 0, 0};
        vecs[2].period = '{5, 2000, 11000, 0};
        vecs[2].exp_freq = '{20_000, 50, 0, 0};
        vecs[2].exp_ns = '{0, 0, 1, 1};

        // Reset state
        repeat (2) @(negedge sys_clk);
        checkOutput("reset freq nonzero", longint'(|freq), 0);
        checkOutput("reset freq_valid", longint'(freq_valid), 0);
        checkOutput("reset no_sig", longint'(no_sig), 0);
        checkOutput("reset busy", busy, 0);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(vecs[k]);
            runToCycle(WIN_CYCLES + 500);
            checkVector(k, vecs[k]);
`ifdef FREQ_METER_RAW_EN
            if (k == 0) begin
                checkOutput("raw_nx ch0", raw_nx[CNT_W-1:0], 1000);
                checkOutput("raw_nr ch0", raw_nr[CNT_W-1:0], 10_000);
            end
`endif
        end

        // Reset while the divider sequence is running
        applyStimulus(vecs[0]);
        while (!busy && tb_cyc < WIN_CYCLES + 100) @(negedge sys_clk);
        checkOutput("busy rises at window end", busy, 1);
        repeat (60) @(negedge sys_clk);
        checkOutput("pre-reset freq ch0", freq[FREQ_W-1:0], 10_000);
        checkOutput("pre-reset busy", busy, 1);
        sys_rst_n = 1'b0;
        #1;
        checkOutput("mid-reset freq nonzero", longint'(|freq), 0);
        checkOutput("mid-reset freq_valid", longint'(freq_valid), 0);
        checkOutput("mid-reset no_sig", longint'(no_sig), 0);
        checkOutput("mid-reset busy", busy, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        runToCycle(WIN_CYCLES - 1);
        total = 0;
        for (int i = 0; i < CH_NUM; i++) total += pulse_cnt[i];
        checkOutput("no pulse before first window", total, 0);
        runToCycle(WIN_CYCLES + 500);
        checkOutput("post-reset ch0 freq", cap_freq[0], 10_000);
        checkOutput("post-reset ch0 pulse time", first_t[0], WIN_CYCLES + DIV_LAT);
        checkOutput("post-reset ch3 pulse count", pulse_cnt[3], 1);
        checkOutput("post-reset ch3 no_sig", cap_ns[3], 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
